// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants for the MIPS core.
// The optional alignment trap is enabled by defining PC_FETCH_ALIGN_CHECK_EN.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: redirect inputs, instruction-memory handshake and fetched-instruction outputs.
// master = fetch stage, slave = surrounding core / memory.
interface pc_fetch_if;
  import cpu_pkg::*;

  logic               Stall;
  logic               JrTaken;
  logic [31:0]        JrTarget;
  logic               JumpTaken;
  logic [31:0]        JumpTarget;
  logic               BranchTaken;
  logic [31:0]        BranchTarget;
  logic               IMReq;
  logic [31:0]        IMAddress;
  logic               IMReady;
  logic [INSTR_W-1:0] IMRdata;
  logic               InstrValid;
  logic [INSTR_W-1:0] Instr;
  logic [31:0]        InstrPC;
  logic [31:0]        PCPlus8;
  logic               AddrExc;

  modport master (
    input  Stall, JrTaken, JrTarget, JumpTaken, JumpTarget, BranchTaken, BranchTarget,
    input  IMReady, IMRdata,
    output IMReq, IMAddress, InstrValid, Instr, InstrPC, PCPlus8, AddrExc
  );

  modport slave (
    output Stall, JrTaken, JrTarget, JumpTaken, JumpTarget, BranchTaken, BranchTarget,
    output IMReady, IMRdata,
    input  IMReq, IMAddress, InstrValid, Instr, InstrPC, PCPlus8, AddrExc
  );

endinterface

// File: rtl/pc_redirect_sel.sv
// Priority redirect mux: JR beats J/JAL beats branch; flags a misaligned winner
// when PC_FETCH_ALIGN_CHECK_EN is defined.
module pc_redirect_sel
  import cpu_pkg::*;
(
  input  logic        jr_taken,
  input  logic [31:0] jr_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
`ifdef PC_FETCH_ALIGN_CHECK_EN
  output logic        redirect_misaligned,
`endif
  output logic        redirect_valid,
  output logic [31:0] redirect_target
);

  // Select the highest-priority pending redirect.
  always_comb begin
    redirect_valid  = 1'b0;
    redirect_target = 32'h0000_0000;
    if (jr_taken) begin
      redirect_valid  = 1'b1;
      redirect_target = jr_target;
    end else if (jump_taken) begin
      redirect_valid  = 1'b1;
      redirect_target = jump_target;
    end else if (branch_taken) begin
      redirect_valid  = 1'b1;
      redirect_target = branch_target;
    end else begin
      redirect_valid  = 1'b0;
      redirect_target = 32'h0000_0000;
    end
  end

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign redirect_misaligned = redirect_valid & addr_misaligned(redirect_target);
`endif

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, issues IM requests and registers Instr/InstrPC.
// Define PC_FETCH_ALIGN_CHECK_EN to trap misaligned redirects into a sticky HALT.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_fetch_if.master   bus
);

  fetch_state_t       state_r, state_s;
  logic [31:0]        pc_r, pc_s;
  logic [INSTR_W-1:0] instr_r, instr_s;
  logic [31:0]        instr_pc_r, instr_pc_s;
  logic               valid_r, valid_s;
  logic               redirect_valid_s;
  logic [31:0]        redirect_target_s;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic               redirect_misaligned_s;
  logic               addr_exc_r, addr_exc_s;
`endif

  pc_redirect_sel u_redirect_sel (
    .jr_taken            (bus.JrTaken),
    .jr_target           (bus.JrTarget),
    .jump_taken          (bus.JumpTaken),
    .jump_target         (bus.JumpTarget),
    .branch_taken        (bus.BranchTaken),
    .branch_target       (bus.BranchTarget),
`ifdef PC_FETCH_ALIGN_CHECK_EN
    .redirect_misaligned (redirect_misaligned_s),
`endif
    .redirect_valid      (redirect_valid_s),
    .redirect_target     (redirect_target_s)
  );

  // Next-state and datapath update; redirect outranks stall, stall outranks capture.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    instr_s    = instr_r;
    instr_pc_s = instr_pc_r;
    valid_s    = valid_r;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    addr_exc_s = addr_exc_r;
`endif
    case (state_r)
      BOOT: begin
        state_s = FETCH;
      end
      FETCH: begin
        if (redirect_valid_s) begin
          pc_s    = redirect_target_s;
          valid_s = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
          if (redirect_misaligned_s) begin
            addr_exc_s = 1'b1;
            state_s    = HALT;
          end else begin
            state_s    = FETCH;
          end
`endif
        end else if (bus.Stall) begin
          valid_s = valid_r;
        end else if (bus.IMReady) begin
          instr_s    = bus.IMRdata;
          instr_pc_s = pc_r;
          valid_s    = 1'b1;
          pc_s       = pc_r + PC_STEP;
        end else begin
          valid_s = 1'b0;
        end
      end
      HALT: begin
        valid_s = 1'b0;
      end
      default: begin
        state_s = BOOT;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      instr_r    <= {INSTR_W{1'b0}};
      instr_pc_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      instr_r    <= instr_s;
      instr_pc_r <= instr_pc_s;
      valid_r    <= valid_s;
    end
  end

`ifdef PC_FETCH_ALIGN_CHECK_EN
  // Sticky misaligned-redirect flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_exc_r <= 1'b0;
    end else begin
      addr_exc_r <= addr_exc_s;
    end
  end
  assign bus.AddrExc = addr_exc_r;
`else
  assign bus.AddrExc = 1'b0;
`endif

  // IMReq follows Stall combinationally so a hazard blocks the request in the same cycle.
  assign bus.IMReq      = (state_r == FETCH) && !bus.Stall;
  assign bus.IMAddress  = pc_r;
  assign bus.InstrValid = valid_r;
  assign bus.Instr      = instr_r;
  assign bus.InstrPC    = instr_pc_r;
  assign bus.PCPlus8    = instr_pc_r + 32'd8;

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Instruction-fetch stage of the MIPS core. It owns the program counter, issues instruction-memory requests, and registers the fetched word together with its PC. Its outputs are InstrPC, Instr[25:0] and PCPlus8. InstrPC and Instr[25:0] feed the downstream J/JAL target generator, and PCPlus8 is the JAL link value. The stage accepts redirect targets (jump, branch, JR) back from decode/execute.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
Stall  input  1  downstream hazard stall; hold fetch outputs
JrTaken  input  1  JR/JALR redirect request
JrTarget  input  32  register-sourced target
JumpTaken  input  1  J/JAL redirect request
JumpTarget  input  32  {InstrPC[31:28], index, 2'b00} from the jump-target generator
BranchTaken  input  1  resolved taken branch
BranchTarget  input  32  branch target
IMReq  output  1  instruction-memory request
IMAddress  output  32  current PC, i.e. the fetch address
IMReady  input  1  IMRdata valid this cycle; request accepted
IMRdata  input  32  fetched instruction word
InstrValid  output  1  Instr/InstrPC hold a live instruction
Instr  output  32  registered instruction
InstrPC  output  32  PC of Instr
PCPlus8  output  32  InstrPC + 8, the link address
AddrExc  output  1  misaligned redirect trapped (only with the optional feature)

Behaviour:
- Reset is asynchronous and active-low, applied on the negedge of rst_n. Reset values:
  - PC = RESET_PC
  - state = BOOT
  - InstrValid = 0, Instr = 0, InstrPC = 0, AddrExc = 0
  - IMReq = 0
- Reset asserted mid-operation aborts any outstanding request immediately. No response is captured afterwards.
- State machine:
  - BOOT: IMReq = 0. Moves unconditionally to FETCH on the next clock, giving one idle cycle after reset release.
  - FETCH: IMReq = !Stall. IMAddress = PC, held stable while IMReq is high and IMReady is low.
  - HALT: (optional feature only) IMReq = 0, InstrValid = 0. Left only by reset.
- Redirect priority: JrTaken > JumpTaken > BranchTaken. Only the winning target is used.
- Per-cycle rules in FETCH (first match wins):
  1. Redirect asserted: PC <= selected target; InstrValid <= 0 (flush). A same-cycle IMReady response is dropped. This rule overrides Stall.
  2. Stall: PC, Instr, InstrPC and InstrValid hold. IMReq = 0, so no capture occurs.
  3. IMReady: Instr <= IMRdata; InstrPC <= PC; InstrValid <= 1; PC <= PC + PC_STEP.
  4. Otherwise (memory wait): InstrValid <= 0 (bubble); PC holds.
- Output latency: one cycle from IMReady to InstrValid.
- PCPlus8 is combinational from InstrPC.
- All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Redirect during BOOT is ignored.

Optional Feature:
- Macro: PC_FETCH_ALIGN_CHECK_EN.
- When defined:
  - A winning redirect target with [1:0] != 0 sets AddrExc <= 1 (sticky) and moves to HALT.
  - The PC is loaded with the faulting target so it can be observed.
- When undefined:
  - Targets are used as-is (low bits pass through to IMAddress).
  - AddrExc is tied to 0 and HALT is unreachable.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch-state enum (BOOT, FETCH, HALT)
  - RESET_PC_DEFAULT = 32'h0000_3000
  - INSTR_W = 32
- Sub-module pc_redirect_sel: combinational priority mux giving redirect_valid and redirect_target. This is the natural place for the alignment check. All other logic stays in the top module.

Test Plan:
- Reset release, IMReady tied 1, IMRdata = 32'h2408_0001 → BOOT for 1 cycle; first IMAddress = 32'h0000_3000; InstrPC = 32'h3000 with InstrValid = 1 one cycle later; PCPlus8 = 32'h3008; next IMAddress = 32'h3004.
- IMReady low for 3 cycles at PC 32'h3008 → IMAddress stays 32'h3008; InstrValid = 0 for 3 cycles; capture on the 4th cycle.
- Stall = 1 for 2 cycles with valid Instr at 32'h3004 → IMReq = 0; Instr, InstrPC and PC unchanged; fetch resumes at 32'h3008 after Stall drops.
- JumpTaken (JumpTarget = 32'h0000_3040), BranchTaken (BranchTarget = 32'h3100) and IMReady asserted in the same cycle → response dropped; InstrValid = 0; next IMAddress = 32'h3040. Then JrTaken + JumpTaken together → the JR target wins.
- Assert rst_n = 0 while IMReq is high and IMReady is low at PC 32'h3010 → immediate IMReq = 0, InstrValid = 0; PC = 32'h3000 after release.
- With PC_FETCH_ALIGN_CHECK_EN defined, JrTaken with JrTarget = 32'h0000_3042 → AddrExc = 1; state HALT; IMReq stays 0 until reset. Without the macro → IMAddress = 32'h3042 and AddrExc = 0.
